// File: rtl/tetris_gfx_pkg.sv
// rtl/tetris_gfx_pkg.sv - shared types, default palette and grid colour (GRID_LINES_EN selects grid use)
package tetris_gfx_pkg;

   typedef logic [2:0] piece_code_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      FL_IDLE = 2'd0,
      FL_ON   = 2'd1,
      FL_OFF  = 2'd2,
      FL_DONE = 2'd3
   } flash_state_t;

   // Entry 0 is the empty-cell backdrop, 1..7 are the I,O,T,S,Z,J,L pieces.
   localparam rgb_t DEFAULT_PALETTE [8] = '{
      '{8'h20, 8'h20, 8'h20},
      '{8'h00, 8'hff, 8'hff},
      '{8'hff, 8'hff, 8'h00},
      '{8'h80, 8'h00, 8'h80},
      '{8'h00, 8'hff, 8'h00},
      '{8'hff, 8'h00, 8'h00},
      '{8'h00, 8'h00, 8'hff},
      '{8'hff, 8'h80, 8'h00}
   };

   localparam rgb_t GRID_COLOR = '{8'h40, 8'h40, 8'h40};

   // Background red level, expressed at 8 bits like the palette.
   localparam logic [7:0] BG_RED = 8'h3f;

   // Widen an 8-bit channel to the 10-bit maximum; callers keep the top COLOR_W bits.
   function automatic logic [9:0] chan_to_10(input logic [7:0] v);
      return {v, 2'b00};
   endfunction

endpackage

// File: rtl/color_palette.sv
// rtl/color_palette.sv - writable piece-code palette with async read and reset reload
module color_palette
   import tetris_gfx_pkg::*;
#(
   parameter int COLOR_W = 8,
   parameter int PIECE_W = 3
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 we,
   input  logic [PIECE_W-1:0]   waddr,
   input  logic [3*COLOR_W-1:0] wdata,
   input  logic [PIECE_W-1:0]   raddr,
   output logic [3*COLOR_W-1:0] rdata
);

   localparam int DEPTH = 2**PIECE_W;

   typedef logic [DEPTH-1:0][3*COLOR_W-1:0] pal_image_t;

   function automatic logic [3*COLOR_W-1:0] default_entry(input int idx);
      rgb_t       c;
      logic [2:0] i3;
      logic [9:0] r10;
      logic [9:0] g10;
      logic [9:0] b10;
      i3  = idx[2:0];
      c   = DEFAULT_PALETTE[i3];
      r10 = chan_to_10(c.r);
      g10 = chan_to_10(c.g);
      b10 = chan_to_10(c.b);
      return {r10[9 -: COLOR_W], g10[9 -: COLOR_W], b10[9 -: COLOR_W]};
   endfunction

   function automatic pal_image_t default_image();
      pal_image_t img;
      for (int i = 0; i < DEPTH; i++) begin
         img[i] = default_entry(i);
      end
      return img;
   endfunction

   localparam pal_image_t RESET_IMAGE = default_image();

   pal_image_t mem;

   // Reset reloads the whole table; otherwise a single-entry write per cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mem <= RESET_IMAGE;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read sees the pre-write contents when a write lands on the same edge.
   assign rdata = mem[raddr];

endmodule

// File: rtl/tile_color_mapper.sv
// rtl/tile_color_mapper.sv - 2-stage board/background colour pipeline with row flash (GRID_LINES_EN adds cell grid lines)
module tile_color_mapper
   import tetris_gfx_pkg::*;
#(
   parameter int COLOR_W      = 8,
   parameter int PIECE_W      = 3,
   parameter int CELL_SHIFT   = 4,
   parameter int BOARD_X0     = 240,
   parameter int BOARD_Y0     = 80,
   parameter int BOARD_COLS   = 10,
   parameter int BOARD_ROWS   = 20,
   parameter int FLASH_FRAMES = 8,
   parameter int FLASH_PULSES = 3
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [9:0]                    DrawX,
   input  logic [9:0]                    DrawY,
   input  logic                          pixel_valid,
   input  logic                          frame_start,
   output logic [$clog2(BOARD_COLS)-1:0] cell_rd_col,
   output logic [$clog2(BOARD_ROWS)-1:0] cell_rd_row,
   input  logic [PIECE_W-1:0]            cell_code,
   input  logic                          pal_we,
   input  logic [PIECE_W-1:0]            pal_addr,
   input  logic [3*COLOR_W-1:0]          pal_data,
   input  logic                          flash_req,
   input  logic [$clog2(BOARD_ROWS)-1:0] flash_row,
   output logic                          flash_busy,
   output logic                          flash_done,
   output logic [COLOR_W-1:0]            VGA_R,
   output logic [COLOR_W-1:0]            VGA_G,
   output logic [COLOR_W-1:0]            VGA_B,
   output logic                          vga_valid
);

   localparam int COL_W       = $clog2(BOARD_COLS);
   localparam int ROW_W       = $clog2(BOARD_ROWS);
   localparam int FRAME_CNT_W = $clog2(FLASH_FRAMES + 1);
   localparam int PULSE_W     = $clog2(FLASH_PULSES + 1);
   localparam int BOARD_X1    = BOARD_X0 + (BOARD_COLS << CELL_SHIFT);
   localparam int BOARD_Y1    = BOARD_Y0 + (BOARD_ROWS << CELL_SHIFT);

   localparam logic [9:0]         BG_R10 = chan_to_10(BG_RED);
   localparam logic [COLOR_W-1:0] BG_R   = BG_R10[9 -: COLOR_W];

   // ---------------- S0: board mapping ----------------
   logic [9:0]         dx;
   logic [9:0]         dy;
   logic               in_board;
   logic [COLOR_W-1:0] bg_b;
   logic               unused_s0;

   assign dx       = DrawX - 10'(BOARD_X0);
   assign dy       = DrawY - 10'(BOARD_Y0);
   assign in_board = (DrawX >= 10'(BOARD_X0)) && (DrawX < 10'(BOARD_X1)) &&
                     (DrawY >= 10'(BOARD_Y0)) && (DrawY < 10'(BOARD_Y1));

   // Addresses are clamped to 0 off-board so the RAM never sees an out-of-range index.
   assign cell_rd_col = in_board ? dx[CELL_SHIFT +: COL_W] : '0;
   assign cell_rd_row = in_board ? dy[CELL_SHIFT +: ROW_W] : '0;

   // Max minus the upper DrawX bits is their bitwise inverse, giving a left-to-right ramp.
   assign bg_b = {1'b0, ~DrawX[9 -: COLOR_W-1]};

   // Only the cell-index bits of the offsets feed addresses; the rest matter for the grid option.
   assign unused_s0 = ^{dx, dy};

   logic               s1_valid;
   logic               s1_in_board;
   logic [ROW_W-1:0]   s1_row;
   logic [COLOR_W-1:0] s1_bg_b;
`ifdef GRID_LINES_EN
   localparam logic [9:0] GRID_R10 = chan_to_10(GRID_COLOR.r);
   localparam logic [9:0] GRID_G10 = chan_to_10(GRID_COLOR.g);
   localparam logic [9:0] GRID_B10 = chan_to_10(GRID_COLOR.b);
   localparam logic [3*COLOR_W-1:0] GRID_RGB =
      {GRID_R10[9 -: COLOR_W], GRID_G10[9 -: COLOR_W], GRID_B10[9 -: COLOR_W]};

   logic grid_px;
   logic s1_grid;

   assign grid_px = (dx[CELL_SHIFT-1:0] == '1) || (dy[CELL_SHIFT-1:0] == '1);

   // Carry the grid-line flag alongside the pixel into S1.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_grid <= 1'b0;
      end else begin
         s1_grid <= grid_px;
      end
   end
`endif

   // S0 -> S1 side-band registers, aligned with the board RAM read latency.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid    <= 1'b0;
         s1_in_board <= 1'b0;
         s1_row      <= '0;
         s1_bg_b     <= '0;
      end else begin
         s1_valid    <= pixel_valid;
         s1_in_board <= in_board;
         s1_row      <= cell_rd_row;
         s1_bg_b     <= bg_b;
      end
   end

   // ---------------- Palette ----------------
   logic [3*COLOR_W-1:0] pal_rdata;

   color_palette #(
      .COLOR_W (COLOR_W),
      .PIECE_W (PIECE_W)
   ) u_palette (
      .Clk   (Clk),
      .Reset (Reset),
      .we    (pal_we),
      .waddr (pal_addr),
      .wdata (pal_data),
      .raddr (cell_code),
      .rdata (pal_rdata)
   );

   // ---------------- Flash FSM ----------------
   flash_state_t           state;
   flash_state_t           state_next;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [PULSE_W-1:0]     pulse_cnt;
   logic [ROW_W-1:0]       flash_row_q;
   logic                   flash_white;
   logic                   phase_end;

   assign phase_end = frame_start && (frame_cnt == FRAME_CNT_W'(FLASH_FRAMES - 1));

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= FL_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state: each ON/OFF phase lasts FLASH_FRAMES frame_start pulses.
   always_comb begin
      state_next = state;
      case (state)
         FL_IDLE: if (flash_req) state_next = FL_ON;
         FL_ON:   if (phase_end) state_next = FL_OFF;
         FL_OFF:  if (phase_end) state_next = (pulse_cnt == PULSE_W'(FLASH_PULSES)) ? FL_DONE : FL_ON;
         FL_DONE: state_next = FL_IDLE;
         default: state_next = FL_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      flash_busy = (state != FL_IDLE);
      flash_done = (state == FL_DONE);
   end

   // Flash counters, latched row, and the displayed white flag which only moves on frame_start.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_cnt   <= '0;
         pulse_cnt   <= '0;
         flash_row_q <= '0;
         flash_white <= 1'b0;
      end else begin
         if (state == FL_IDLE && flash_req) begin
            frame_cnt   <= '0;
            pulse_cnt   <= '0;
            flash_row_q <= flash_row;
         end else if ((state == FL_ON || state == FL_OFF) && frame_start) begin
            frame_cnt <= phase_end ? '0 : frame_cnt + 1'b1;
            if (state == FL_ON && phase_end) begin
               pulse_cnt <= pulse_cnt + 1'b1;
            end
         end
         if (frame_start) begin
            flash_white <= (state_next == FL_ON);
         end
      end
   end

   // ---------------- S1: colour select ----------------
   logic [3*COLOR_W-1:0] pix_rgb;

   // Priority: blank, background ramp, [grid], flash white, palette.
   always_comb begin
      pix_rgb = '0;
      if (!s1_valid) begin
         pix_rgb = '0;
      end else if (!s1_in_board) begin
         pix_rgb = {BG_R, {COLOR_W{1'b0}}, s1_bg_b};
`ifdef GRID_LINES_EN
      end else if (s1_grid) begin
         pix_rgb = GRID_RGB;
`endif
      end else if (flash_white && (s1_row == flash_row_q)) begin
         pix_rgb = '1;
      end else begin
         pix_rgb = pal_rdata;
      end
   end

   // Output registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         vga_valid <= 1'b0;
      end else begin
         VGA_R     <= pix_rgb[3*COLOR_W-1 -: COLOR_W];
         VGA_G     <= pix_rgb[2*COLOR_W-1 -: COLOR_W];
         VGA_B     <= pix_rgb[COLOR_W-1:0];
         vga_valid <= s1_valid;
      end
   end

endmodule

// File: tb/tb_tile_color_mapper.sv
// tb/tb_tile_color_mapper.sv - randomized self-checking bench for tile_color_mapper
module tb_tile_color_mapper;

   localparam int FF    = 2;
   localparam int NP    = 3;
   localparam int TOTAL = 2 * FF * NP;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        pixel_valid;
   logic        frame_start;
   logic [3:0]  cell_rd_col;
   logic [4:0]  cell_rd_row;
   logic [2:0]  cell_code;
   logic        pal_we;
   logic [2:0]  pal_addr;
   logic [23:0] pal_data;
   logic        flash_req;
   logic [4:0]  flash_row;
   logic        flash_busy;
   logic        flash_done;
   logic [7:0]  VGA_R;
   logic [7:0]  VGA_G;
   logic [7:0]  VGA_B;
   logic        vga_valid;

   always #5 Clk = ~Clk;

   tile_color_mapper #(
      .FLASH_FRAMES (FF),
      .FLASH_PULSES (NP)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .pixel_valid (pixel_valid),
      .frame_start (frame_start),
      .cell_rd_col (cell_rd_col),
      .cell_rd_row (cell_rd_row),
      .cell_code   (cell_code),
      .pal_we      (pal_we),
      .pal_addr    (pal_addr),
      .pal_data    (pal_data),
      .flash_req   (flash_req),
      .flash_row   (flash_row),
      .flash_busy  (flash_busy),
      .flash_done  (flash_done),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .vga_valid   (vga_valid)
   );

   // Board RAM model: one-cycle registered read.
   logic [2:0] board [20][10];
   always @(posedge Clk) cell_code <= board[cell_rd_row][cell_rd_col];

   int done_seen = 0;
   always @(negedge Clk) if (flash_done === 1'b1) done_seen++;

   localparam logic [23:0] DEF_PAL [8] = '{24'h202020, 24'h00ffff, 24'hffff00, 24'h800080,
                                           24'h00ff00, 24'hff0000, 24'h0000ff, 24'hff8000};

   logic [23:0] pal_m [8];
   int          m_state;   // 0 idle, 1 running, 2 done
   int          m_k;       // frame_start pulses since acceptance
   int          m_row;
   logic        m_white;
   logic [9:0]  px;
   logic [9:0]  py;
   logic        pv;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic in_brd(input int x, input int y);
      return x >= 240 && x < 400 && y >= 80 && y < 400;
   endfunction

   function automatic logic [23:0] model_rgb(input int x, input int y, input logic v);
      int cx;
      int cy;
      if (!v) return 24'h0;
      if (!in_brd(x, y)) return {8'h3f, 8'h00, 8'(127 - x / 8)};
`ifdef GRID_LINES_EN
      if ((x - 240) % 16 == 15 || (y - 80) % 16 == 15) return 24'h404040;
`endif
      cx = (x - 240) / 16;
      cy = (y - 80) / 16;
      if (m_white && cy == m_row) return 24'hffffff;
      return pal_m[board[cy][cx]];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) pal_m[i] = DEF_PAL[i];
      m_state = 0;
      m_k     = 0;
      m_row   = 0;
      m_white = 1'b0;
      pv      = 1'b0;
   endtask

   // One clock: check combinational addresses, clock, then check the previous pixel's colour.
   task automatic tick();
      int          x;
      int          y;
      logic        v;
      logic        c_rst;
      logic        c_we;
      logic [2:0]  c_wa;
      logic [23:0] c_wd;
      logic        c_req;
      logic        c_fs;
      int          c_frow;
      x = int'(DrawX); y = int'(DrawY); v = pixel_valid; c_rst = Reset;
      c_we = pal_we; c_wa = pal_addr; c_wd = pal_data;
      c_req = flash_req; c_fs = frame_start; c_frow = int'(flash_row);
      #1;
      if (!c_rst) begin
         check("rd_col", 32'(cell_rd_col), in_brd(x, y) ? 32'((x - 240) / 16) : 32'd0);
         check("rd_row", 32'(cell_rd_row), in_brd(x, y) ? 32'((y - 80) / 16) : 32'd0);
      end
      @(posedge Clk);
      #1;
      if (c_rst) begin
         model_reset();
         check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
         check("rst_valid", 32'(vga_valid), 32'd0);
      end else begin
         check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(model_rgb(int'(px), int'(py), pv)));
         check("vga_valid", 32'(vga_valid), 32'(pv));
         if (c_we) pal_m[c_wa] = c_wd;
         if (c_fs && m_state != 1) m_white = 1'b0;
         case (m_state)
            0: if (c_req) begin m_state = 1; m_k = 0; m_row = c_frow; end
            1: if (c_fs) begin
                  m_k++;
                  m_white = ((m_k / FF) % 2 == 0) && (m_k < TOTAL);
                  if (m_k == TOTAL) m_state = 2;
               end
            default: m_state = 0;
         endcase
         px = 10'(x); py = 10'(y); pv = v;
      end
      check("busy", 32'(flash_busy), 32'(m_state != 0));
      check("done", 32'(flash_done), 32'(m_state == 2));
   endtask

   task automatic pix(input int x, input int y, input logic v);
      DrawX = 10'(x); DrawY = 10'(y); pixel_valid = v;
      tick();
   endtask

   task automatic row_pix(input int r);
      pix(240 + $urandom_range(0, 159), 80 + r * 16 + $urandom_range(0, 15), 1'b1);
   endtask

   initial begin
      Reset = 1'b1; DrawX = '0; DrawY = '0; pixel_valid = 1'b0; frame_start = 1'b0;
      pal_we = 1'b0; pal_addr = '0; pal_data = '0; flash_req = 1'b0; flash_row = '0;
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 10; c++) board[r][c] = 3'($urandom_range(0, 7));
      board[0][0] = 3'd1;
      board[5][2] = 3'd3;
      model_reset();

      tick();
      tick();
      Reset = 1'b0;

      // Directed: default palette, background ramp ends, board edges, piece lookup.
      pix(240, 80, 1'b1);
      pix(0, 0, 1'b1);
      pix(639, 0, 1'b1);
      pix(1023, 5, 1'b1);
      pix(280, 168, 1'b1);
      pix(239, 80, 1'b1);
      pix(240, 79, 1'b1);
      pix(399, 399, 1'b1);
      pix(400, 200, 1'b1);
      pix(300, 400, 1'b1);
      pix(0, 0, 1'b0);

      // Write to entry 3 while S1 reads code 3, then the next pixel sees the new value.
      pix(280, 168, 1'b1);
      pal_we = 1'b1; pal_addr = 3'd3; pal_data = 24'h123456;
      pix(281, 170, 1'b1);
      pal_we = 1'b0;
      pix(282, 171, 1'b1);
      pix(0, 0, 1'b0);

      // Random pixels with occasional palette writes.
      for (int i = 0; i < 300; i++) begin
         pal_we   = ($urandom_range(0, 7) == 0);
         pal_addr = 3'($urandom_range(0, 7));
         pal_data = 24'($urandom);
         if ($urandom_range(0, 1) == 1)
            pix(240 + $urandom_range(0, 159), 80 + $urandom_range(0, 319), $urandom_range(0, 7) != 0);
         else
            pix($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 7) != 0);
      end
      pal_we = 1'b0;

      // Full flash sequence on row 5 with a second request ignored mid-way.
      flash_row = 5'd5; flash_req = 1'b1;
      row_pix(5);
      flash_req = 1'b0;
      for (int f = 1; f <= TOTAL + 2; f++) begin
         for (int j = 0; j < 6; j++) begin
            if (f == 5 && j == 2) begin flash_row = 5'd7; flash_req = 1'b1; end
            row_pix(5 + (j % 3));
            flash_req = 1'b0;
         end
         frame_start = 1'b1;
         row_pix(5);
         frame_start = 1'b0;
      end
      row_pix(5);
      check("done_pulses", 32'(done_seen), 32'd1);

      // Reset during a white phase.
      flash_row = 5'd5; flash_req = 1'b1;
      row_pix(5);
      flash_req = 1'b0;
      frame_start = 1'b1;
      row_pix(5);
      frame_start = 1'b0;
      for (int j = 0; j < 4; j++) row_pix(5);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      for (int f = 0; f < 4; f++) begin
         for (int j = 0; j < 4; j++) row_pix(5);
         frame_start = 1'b1;
         row_pix(5);
         frame_start = 1'b0;
      end
      pix(0, 0, 1'b0);
      pix(0, 0, 1'b0);
      check("done_after_reset", 32'(done_seen), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
